// File: rtl/pacman_pkg.sv
// pacman_pkg: shared game-flow types and constants
//   state_t        : 3-bit FSM state codes (IDLE..OVER)
//   BND_W          : width of one bounding-box coordinate
//   NUM_GHOSTS     : number of ghosts checked for collision
//   PELLET_PTS_DEF : default points per pellet
//   SCORE_MAX_DEF  : default score saturation value
package pacman_pkg;
    localparam int BND_W          = 10;
    localparam int NUM_GHOSTS     = 4;
    localparam int PELLET_PTS_DEF = 10;
    localparam int SCORE_MAX_DEF  = 9999;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DYING = 3'd3,
        WIN   = 3'd4,
        OVER  = 3'd5
    } state_t;
endpackage

// File: rtl/game_flow_ctrl_box_overlap.sv
// box_overlap: inclusive overlap test of two {l,r,t,b} boxes
//   pac     in  40  first box  {l,r,t,b}
//   ghost   in  40  second box {l,r,t,b}
//   overlap out 1   high when the boxes share at least one point
module box_overlap import pacman_pkg::*; (
    input  logic [4*BND_W-1:0] pac,
    input  logic [4*BND_W-1:0] ghost,
    output logic               overlap
);
    logic [BND_W-1:0] pl, pr, pt, pb, gl, gr, gt, gb;
    assign {pl, pr, pt, pb} = pac;
    assign {gl, gr, gt, gb} = ghost;
    assign overlap = (pl <= gr) && (gl <= pr) && (pt <= gb) && (gt <= pb);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Pac-Man game flow FSM with lives, score and ghost collision
//   clk          in  1    system clock
//   rst          in  1    asynchronous active-low reset
//   tick         in  1    game-step pulse
//   start        in  1    start/restart pulse (honoured in IDLE, WIN, OVER)
//   pellet_eaten in  1    pellet pulse, scored only in PLAY
//   pellets_zero in  1    level, no pellets left
//   pacman_bnd   in  40   Pac-Man box {l,r,t,b}
//   ghost_bnd    in  160  ghost i box at [40i+39:40i]
//   state        out 3    FSM state code
//   move_en      out 1    movement enable (PLAY only)
//   ghost_home   out 1    one-clk pulse on every entry to READY
//   lives        out 2    remaining lives
//   score        out 16   saturating binary score
//   game_over    out 1    high in OVER
//   win          out 1    high in WIN
// Build option: define EXTRA_LIFE_EN for one bonus life per game at 1000 points.
module game_flow_ctrl import pacman_pkg::*; #(
    parameter int READY_TICKS = 3,
    parameter int DEATH_TICKS = 2,
    parameter int PELLET_PTS  = PELLET_PTS_DEF,
    parameter int SCORE_MAX   = SCORE_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          pellet_eaten,
    input  logic                          pellets_zero,
    input  logic [4*BND_W-1:0]            pacman_bnd,
    input  logic [NUM_GHOSTS*4*BND_W-1:0] ghost_bnd,
    output logic [2:0]                    state,
    output logic                          move_en,
    output logic                          ghost_home,
    output logic [1:0]                    lives,
    output logic [15:0]                   score,
    output logic                          game_over,
    output logic                          win
);
    localparam int CW = $clog2((READY_TICKS > DEATH_TICKS ? READY_TICKS : DEATH_TICKS) + 1);
    state_t          st, st_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      lives_nxt, lives_fin;
    logic [15:0]     score_nxt;
    logic [16:0]     sum;
    logic [NUM_GHOSTS-1:0] ov;
    logic            hit, go;
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ov
        box_overlap u_ov (
            .pac     (pacman_bnd),
            .ghost   (ghost_bnd[g*4*BND_W +: 4*BND_W]),
            .overlap (ov[g])
        );
    end
    assign go      = start && (st == IDLE || st == WIN || st == OVER);
    assign sum     = {1'b0, score} + 17'(PELLET_PTS);
    assign state   = st;
    assign move_en = (st == PLAY);
    always_comb begin
        st_nxt    = st;
        lives_nxt = lives;
        score_nxt = score;
        cnt_nxt   = (tick && (st == READY || st == DYING)) ? cnt + CW'(1) : cnt;
        case (st)
            IDLE, WIN, OVER: begin
                if (go) begin
                    st_nxt    = READY;
                    lives_nxt = 2'd3;
                    score_nxt = '0;
                end
            end
            READY: st_nxt = (tick && cnt == CW'(READY_TICKS - 1)) ? PLAY : READY;
            PLAY: begin
                st_nxt    = pellets_zero ? WIN : hit ? DYING : PLAY;
                // scored on the current state, so a pellet on the exit clk still counts
                score_nxt = !pellet_eaten ? score : (sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : sum[15:0];
            end
            DYING: begin
                if (tick && cnt == CW'(DEATH_TICKS - 1)) begin
                    st_nxt    = (lives == 2'd1) ? OVER : READY;
                    lives_nxt = lives - 2'd1;
                end
            end
            default: st_nxt = IDLE;
        endcase
        if (st_nxt != st) cnt_nxt = '0;
    end
`ifdef EXTRA_LIFE_EN
    logic bonus, bonus_nxt;
    // bonus is applied on the same clk the score crosses 1000, so it never races a death
    always_comb begin
        bonus_nxt = go ? 1'b0 : (bonus || score_nxt >= 16'd1000);
        lives_fin = (!bonus && score_nxt >= 16'd1000) ? ((lives_nxt == 2'd3) ? 2'd3 : lives_nxt + 2'd1) : lives_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bonus <= 1'b0;
        else      bonus <= bonus_nxt;
    end
`else
    assign lives_fin = lives_nxt;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            cnt        <= '0;
            lives      <= '0;
            score      <= '0;
            hit        <= 1'b0;
            ghost_home <= 1'b0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            lives      <= lives_fin;
            score      <= score_nxt;
            hit        <= |ov;
            ghost_home <= (st_nxt == READY) && (st != READY);
            game_over  <= (st_nxt == OVER);
            win        <= (st_nxt == WIN);
        end
    end
endmodule
